// File: rtl/dmem_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_bus_bridge
//  Description : Data-side memory subsystem for the core's load/store port.
//                Decodes each access to a byte-maskable data RAM, a LED
//                register, or a memory-mapped 8N1 UART transmitter with a
//                status register. Loads are captured on the falling clock
//                edge; stores and all other state update on the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_bus_bridge #(
  parameter int RAM_WORDS    = 256,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_out,
  input  logic [3:0]  mem_mask,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] mem_in,
  output logic [31:0] leds,
  output logic        uart_tx,
  output logic        bus_err
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Address decode (only the low 4 KiB window is mapped)
  // --------------------------------------------------------------------------
  logic          hi_zero;
  logic          ram_sel;
  logic          led_sel;
  logic          tx_sel;
  logic          stat_sel;
  logic          unmapped;
  logic [AW-1:0] ram_idx;

  assign hi_zero  = (mem_address[31:12] == 20'd0);
  assign ram_sel  = hi_zero && (mem_address[11:10] == 2'b00);
  assign led_sel  = hi_zero && (mem_address[11:0] == 12'h400);
  assign tx_sel   = hi_zero && (mem_address[11:0] == 12'h404);
  assign stat_sel = hi_zero && (mem_address[11:0] == 12'h408);
  assign unmapped = !(ram_sel || led_sel || tx_sel || stat_sel);
  // Byte-offset bits are ignored; lane selection comes from mem_mask.
  assign ram_idx  = mem_address[AW+1:2];

  // --------------------------------------------------------------------------
  // UART handshake signals
  // --------------------------------------------------------------------------
  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          busy;
  logic          tx_write;
  logic          tx_accept;
  logic          tx_overrun;

  // Overrun is set on the rising edge and cleared on the falling edge, so it
  // is split into two toggle flags, one per edge; their XOR is the flag.
  logic          ovr_set;
  logic          ovr_clr;
  logic          overrun;

  assign busy       = (state != IDLE);
  assign tx_write   = mem_write && tx_sel && mem_mask[0];
  assign tx_accept  = tx_write && !busy;
  assign tx_overrun = tx_write && busy;
  assign overrun    = ovr_set ^ ovr_clr;

  // --------------------------------------------------------------------------
  // Data RAM (contents survive reset)
  // --------------------------------------------------------------------------
  logic [31:0] ram [RAM_WORDS];

  // Byte-lane masked RAM store on the rising edge
  always_ff @(posedge clk) begin
    if (mem_write && ram_sel) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_mask[b]) begin
          ram[ram_idx][8*b +: 8] <= mem_out[8*b +: 8];
        end
      end
    end
  end

  // Byte-lane masked LED register store
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      leds <= 32'd0;
    end else if (mem_write && led_sel) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_mask[b]) begin
          leds[8*b +: 8] <= mem_out[8*b +: 8];
        end
      end
    end
  end

  // One-cycle error pulse after any access to an unmapped address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_err <= 1'b0;
    end else begin
      bus_err <= (mem_read || mem_write) && unmapped;
    end
  end

  // Load path: capture decoded word on the falling edge; reading the status
  // register consumes the overrun flag in the same edge
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      mem_in  <= 32'd0;
      ovr_clr <= 1'b0;
    end else if (mem_read) begin
      if (ram_sel) begin
        mem_in <= ram[ram_idx];
      end else if (led_sel) begin
        mem_in <= leds;
      end else if (stat_sel) begin
        mem_in <= {30'd0, overrun, busy};
        if (overrun) begin
          ovr_clr <= ~ovr_clr;
        end
      end else begin
        mem_in <= 32'd0;
      end
    end
  end

  // Overrun set side: a dropped transmit write raises the flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_set <= 1'b0;
    end else if (tx_overrun && !overrun) begin
      ovr_set <= ~ovr_set;
    end
  end

  // UART 8N1 transmitter, LSB first, registered line output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= 3'd0;
      shreg   <= 8'd0;
      uart_tx <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          cnt     <= '0;
          if (tx_accept) begin
            shreg   <= mem_out[7:0];
            uart_tx <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (cnt == CNT_MAX) begin
            cnt     <= '0;
            idx     <= 3'd0;
            uart_tx <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            state   <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == CNT_MAX) begin
            cnt <= '0;
            if (idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              idx     <= idx + 3'd1;
              uart_tx <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_MAX) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_bus_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_bus_bridge
//  Description : Self-checking bench for dmem_bus_bridge. Directed scenarios
//                followed by randomized traffic, all compared each cycle
//                against a behavioural model of the memory map and UART frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_bus_bridge;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_address = '0;
  logic [31:0] mem_out = '0;
  logic [3:0]  mem_mask = '0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_in;
  logic [31:0] leds;
  logic        uart_tx;
  logic        bus_err;

  dmem_bus_bridge #(
    .RAM_WORDS   (256),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_address(mem_address),
    .mem_out    (mem_out),
    .mem_mask   (mem_mask),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_in     (mem_in),
    .leds       (leds),
    .uart_tx    (uart_tx),
    .bus_err    (bus_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [31:0] m_ram [256];
  logic [31:0] m_leds   = '0;
  logic [31:0] m_mem_in = '0;
  bit          m_err    = 1'b0;
  bit          m_ovr    = 1'b0;
  bit          tx_active = 1'b0;
  int          tx_start  = 0;
  logic [7:0]  tx_byte   = '0;
  int          cyc       = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // A frame lasts FRAME cycles counted from the edge that accepted the write.
  function automatic bit m_busy();
    return tx_active && ((cyc - tx_start) < FRAME);
  endfunction

  // Line level: start bit, 8 data bits LSB first, stop bit, each CPB wide.
  function automatic logic m_tx();
    int d;
    if (!m_busy()) return 1'b1;
    d = (cyc - tx_start) / CPB;
    if (d == 0) return 1'b0;
    if (d == 9) return 1'b1;
    return tx_byte[d-1];
  endfunction

  task automatic check_all();
    chk("mem_in",  mem_in,  m_mem_in);
    chk("leds",    leds,    m_leds);
    chk("bus_err", {31'd0, bus_err}, {31'd0, m_err});
    chk("uart_tx", {31'd0, uart_tx}, {31'd0, m_tx()});
  endtask

  // One bus cycle: drive at posedge+1, model the access, check after next edge.
  task automatic do_cycle(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] mk);
    bit hz, rs, ls, ts, ss, bsy;
    mem_address = a;
    mem_out     = d;
    mem_mask    = mk;
    mem_read    = rd;
    mem_write   = wr;
    hz  = (a[31:12] == 20'd0);
    rs  = hz && (a[11:0] < 12'h400);
    ls  = (a == 32'h400);
    ts  = (a == 32'h404);
    ss  = (a == 32'h408);
    bsy = m_busy();
    // Load sees contents before any store of the same cycle
    if (rd) begin
      if (rs)      m_mem_in = m_ram[a[9:2]];
      else if (ls) m_mem_in = m_leds;
      else if (ss) begin
        m_mem_in = {30'd0, m_ovr, bsy};
        m_ovr    = 1'b0;
      end
      else         m_mem_in = 32'd0;
    end
    @(posedge clk);
    cyc++;
    m_err = (rd || wr) && !(rs || ls || ts || ss);
    if (wr) begin
      for (int b = 0; b < 4; b++) begin
        if (mk[b] && rs) m_ram[a[9:2]][8*b +: 8] = d[8*b +: 8];
        if (mk[b] && ls) m_leds[8*b +: 8] = d[8*b +: 8];
      end
      if (ts && mk[0]) begin
        if (bsy) m_ovr = 1'b1;
        else begin
          tx_active = 1'b1;
          tx_start  = cyc;
          tx_byte   = d[7:0];
        end
      end
    end
    #1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  logic [31:0] unm [6] = '{32'h40C, 32'h800, 32'h2000, 32'hFFC, 32'h8000_0010, 32'h1400};

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    do_cycle(1'b1, 1'b0, 32'h408, 32'h0, 4'h0);
    chk("stat_after_reset", mem_in, 32'h0);

    // Give every RAM word a known value
    for (int i = 0; i < 256; i++) do_cycle(1'b0, 1'b1, i * 4, $urandom, 4'hF);

    // Byte-masked RAM store
    do_cycle(1'b0, 1'b1, 32'h010, 32'h11223344, 4'b1111);
    do_cycle(1'b0, 1'b1, 32'h010, 32'hAABBCCDD, 4'b0101);
    do_cycle(1'b1, 1'b0, 32'h010, 32'h0, 4'h0);
    chk("ram_mask", mem_in, 32'h11BB33DD);

    // LED register
    do_cycle(1'b0, 1'b1, 32'h400, 32'h000000A5, 4'b0001);
    chk("led_write", leds, 32'h000000A5);
    do_cycle(1'b1, 1'b0, 32'h400, 32'h0, 4'h0);
    chk("led_read", mem_in, 32'h000000A5);

    // UART frame, busy status and overrun
    do_cycle(1'b0, 1'b1, 32'h404, 32'h53, 4'b0001);
    idle(5);
    do_cycle(1'b1, 1'b0, 32'h408, 32'h0, 4'h0);
    chk("stat_busy", mem_in, 32'h1);
    do_cycle(1'b0, 1'b1, 32'h404, 32'h77, 4'b0001);
    do_cycle(1'b1, 1'b0, 32'h408, 32'h0, 4'h0);
    chk("stat_overrun", mem_in, 32'h3);
    idle(35);
    do_cycle(1'b1, 1'b0, 32'h408, 32'h0, 4'h0);
    chk("stat_done", mem_in, 32'h0);

    // Unmapped access
    do_cycle(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0);
    chk("unmapped_data", mem_in, 32'h0);
    chk("unmapped_err", {31'd0, bus_err}, 32'h1);
    idle(1);

    // Reset in the middle of DATA aborts the frame at once
    do_cycle(1'b0, 1'b1, 32'h404, 32'h53, 4'b0001);
    idle(17);
    rst = 1'b1;
    #1;
    chk("abort_tx", {31'd0, uart_tx}, 32'h1);
    tx_active = 1'b0;
    m_ovr     = 1'b0;
    m_leds    = '0;
    m_mem_in  = '0;
    m_err     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
    do_cycle(1'b1, 1'b0, 32'h408, 32'h0, 4'h0);
    chk("abort_busy", mem_in, 32'h0);

    // Randomized traffic
    for (int it = 0; it < 800; it++) begin
      int kind, op;
      logic [31:0] a;
      bit rd, wr;
      kind = $urandom_range(0, 15);
      op   = $urandom_range(0, 2);
      rd   = (op != 1);
      wr   = (op != 0);
      if (kind <= 7)       a = $urandom_range(0, 255) * 4 + $urandom_range(0, 3);
      else if (kind <= 9)  a = 32'h400;
      else if (kind == 10) a = ($urandom_range(0, 2) == 0) ? 32'h404 : 32'h408;
      else if (kind <= 12) a = 32'h408;
      else if (kind == 13) a = unm[$urandom_range(0, 5)];
      else begin
        a  = 32'h0;
        rd = 1'b0;
        wr = 1'b0;
      end
      do_cycle(rd, wr, a, $urandom, 4'($urandom_range(0, 15)));
    end
    idle(FRAME + 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
Data-side memory subsystem that consumes the RV32nexpo core's load/store port (mem_address, mem_out, mem_mask, mem_read, mem_write) and returns mem_in. It decodes each access to one of three targets: a 256-word byte-maskable data RAM, a LED output register, or a memory-mapped UART transmitter with a status register. It replaces the ad-hoc RAM/LED logic around the core and sits directly downstream of its memory stage.

Parameters:
RAM_WORDS, 256, data RAM depth in 32-bit words; indexed by mem_address[9:2].
CLKS_PER_BIT, 4, clk cycles per UART bit; minimum legal value is 2.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  asynchronous, active-high reset.
mem_address  in  32  byte address from the core.
mem_out  in  32  store data from the core.
mem_mask  in  4  byte-lane write enables; bit n covers bits [8n+7:8n].
mem_read  in  1  load request, valid for one cycle.
mem_write  in  1  store request, valid for one cycle.
mem_in  out  32  load data returned to the core.
leds  out  32  LED register contents.
uart_tx  out  1  serial line; idles high.
bus_err  out  1  one-cycle pulse on an access to an unmapped address.

Behaviour:
- Reset (async, rst=1): mem_in=0, leds=0, uart_tx=1, bus_err=0, UART FSM=IDLE, overrun=0. RAM contents are not cleared.
- Address map (decode only when mem_address[31:12]==0):
  - 0x000–0x3FF: RAM.
  - 0x400: LED (RW).
  - 0x404: UART_TX (W only; reads return 0).
  - 0x408: UART_STAT (R; bit0=busy, bit1=overrun, others 0).
  - Any other address: unmapped.
- Read timing: on the falling edge of clk in a cycle with mem_read=1, mem_in takes the decoded word. The data is stable for the core at the next rising edge. mem_in holds its value when mem_read=0. A read of an unmapped address returns 0.
- Write timing: on the rising edge with mem_write=1.
  - RAM: only the lanes enabled in mem_mask are written.
  - LED: same per-lane rule.
  - UART_TX: only mem_out[7:0] is used; the write is accepted if lane 0 is enabled.
- mem_read and mem_write asserted together: both are performed. The read returns the pre-write contents.
- bus_err: registered and asserted for exactly one cycle after any read or write to an unmapped address. No state changes on that access.
- UART FSM, 8N1, LSB first:
  - IDLE: uart_tx=1. An accepted UART_TX write latches the byte, sets busy, and moves to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, each held for CLKS_PER_BIT cycles. A 3-bit index is used and the FSM leaves after index 7.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then IDLE; busy clears.
  - A byte takes exactly 10*CLKS_PER_BIT cycles from the first START cycle to the return to IDLE.
  - The baud counter restarts at every state change.
- Overrun: a UART_TX write while busy=1 is dropped and sets overrun. A UART_STAT read returns the current overrun value and clears it on the same falling edge. If a new overrun occurs in that same cycle, overrun stays set.
- The UART_TX write that returns the FSM to IDLE is taken at the next rising edge only if busy is already 0. Otherwise it counts as an overrun.
- rst asserted mid-transmission aborts immediately: uart_tx=1, IDLE, busy=0.
- RAM index wrap: only mem_address[9:2] is used. Byte-offset bits [1:0] are ignored; the core supplies lane selection via mem_mask.

Test Plan:
- Reset: rst=1 for 3 cycles -> mem_in=0, leds=0, uart_tx=1, bus_err=0. A read of 0x408 returns 0.
- Byte-mask RAM:
  - Write 0x11223344 to 0x010 with mask 4'b1111, then 0xAABBCCDD with mask 4'b0101.
  - Read 0x010 -> mem_in=0x11BB33DD, valid at the rising edge after the read cycle.
- LED: write 0x0000_00A5 to 0x400 with mask 4'b0001 -> leds=0x000000A5 next cycle; a read of 0x400 returns the same.
- UART:
  - Write 0x53 to 0x404 with CLKS_PER_BIT=4.
  - uart_tx shows 0,1,1,0,0,1,0,1,0,1, each bit 4 cycles wide.
  - 0x408 reads 1 during the transmission and 0 after 40 cycles.
- Overrun:
  - Second write to 0x404 while busy -> byte not sent; 0x408 reads 0x3.
  - A subsequent read after the transmission completes gives 0x0.
- Unmapped/abort:
  - Read 0x2000 -> mem_in=0 and a one-cycle bus_err.
  - rst pulse in the middle of the DATA state -> uart_tx=1 at once, busy=0 after release.
